// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: word width, receiver state encoding, Galois next-word function.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
// Used by the receiver (lfsr_sync_rx) and by any matching generator so both sides
// agree on the exact sequence, including the lock-up-free treatment of 8'h00.
package lfsr_pkg;

  localparam int LFSR_W = 8;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Galois step with the all-zero word folded into the sequence: the feedback bit
  // is inverted when the low seven bits are zero, so 8'h80 -> 8'h00 -> 8'h1D.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
    logic              f;
    logic [LFSR_W-1:0] n;
    f    = x[7] ^ (x[6:0] == 7'd0);
    n[0] = f;
    n[1] = x[0];
    n[2] = x[1] ^ f;
    n[3] = x[2] ^ f;
    n[4] = x[3] ^ f;
    n[5] = x[4];
    n[6] = x[5];
    n[7] = x[6];
    return n;
  endfunction

endpackage

// File: rtl/lfsr_galois_next.sv
// Combinational LFSR predictor: returns the word that follows i_word in the sequence.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: i_word [7:0] current word, o_next [7:0] successor word.
module lfsr_galois_next
  import lfsr_pkg::*;
(
  input  logic [7:0] i_word,
  output logic [7:0] o_next
);

  assign o_next = lfsr_next(i_word);

endmodule

// File: rtl/lfsr_sync_rx.sv
// LFSR sequence receiver: acquires lock on a PRBS word stream, flywheels, flags mismatches.
// Latency: o_lock/o_err/o_err_cnt update one cycle after the accepted word.
// Backpressure: none; every i_valid word is consumed, idle cycles freeze all state.
// Ports: clk, i_rst_n (sync, active-low), i_valid/i_lfsr word input, i_clr_cnt count clear,
//        o_lock lock status, o_err mismatch pulse while locked, o_err_cnt mismatch count.
// Build option: define LFSR_SYNC_RX_ERR_CNT_EN to build the error counter; otherwise
// o_err_cnt is tied to zero and i_clr_cnt has no effect.
module lfsr_sync_rx
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT   = 5,
  parameter int UNLOCK_CNT = 3
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [7:0]  i_lfsr,
  input  logic        i_clr_cnt,
  output logic        o_lock,
  output logic        o_err,
  output logic [15:0] o_err_cnt
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);
  localparam logic [MATCH_W-1:0] LOCK_LAST   = MATCH_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0]  UNLOCK_LAST = MISS_W'(UNLOCK_CNT);

  state_t             state_q, state_d;
  logic [7:0]         expected_q, expected_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic               lock_q, lock_d;
  logic               err_q, err_d;

  logic [7:0]         pred_in;   // successor of the received word (acquisition)
  logic [7:0]         pred_exp;  // successor of the prediction (flywheel)
  logic               match;
  logic [MATCH_W-1:0] match_inc;
  logic [MISS_W-1:0]  miss_inc;
  logic               lock_hit;
  logic               unlock_hit;

  lfsr_galois_next u_pred_in  (.i_word(i_lfsr),     .o_next(pred_in));
  lfsr_galois_next u_pred_exp (.i_word(expected_q), .o_next(pred_exp));

  assign match      = (i_lfsr == expected_q);
  assign match_inc  = match_cnt_q + MATCH_W'(1);
  assign miss_inc   = miss_cnt_q + MISS_W'(1);
  assign lock_hit   = (match_inc == LOCK_LAST);
  assign unlock_hit = (miss_inc == UNLOCK_LAST);

  // State register plus the datapath flops that travel with it.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q     <= SEARCH;
      expected_q  <= 8'h00;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      lock_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      lock_q      <= lock_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic: transitions only happen on accepted words.
  always_comb begin
    state_d = state_q;
    if (i_valid) begin
      unique case (state_q)
        SEARCH:  state_d = VERIFY;
        VERIFY:  if (match && lock_hit) state_d = LOCKED;
        LOCKED:  if (!match && unlock_hit) state_d = SEARCH;
        default: state_d = SEARCH;
      endcase
    end
  end

  // Datapath and registered outputs.
  always_comb begin
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_d       = 1'b0;
    lock_d      = (state_d == LOCKED);
    if (i_valid) begin
      unique case (state_q)
        SEARCH: begin
          expected_d  = pred_in;
          match_cnt_d = '0;
          miss_cnt_d  = '0;
        end
        VERIFY: begin
          // A mismatch here just reseeds from the received word; it is not an error.
          expected_d  = pred_in;
          match_cnt_d = match ? match_inc : '0;
          miss_cnt_d  = '0;
        end
        LOCKED: begin
          // Flywheel: never trust the line while locked, so corrupted words
          // cannot pull the prediction off the sequence.
          expected_d = pred_exp;
          if (match) begin
            miss_cnt_d = '0;
          end else begin
            err_d       = 1'b1;
            miss_cnt_d  = unlock_hit ? '0 : miss_inc;
            match_cnt_d = '0;
          end
        end
        default: begin
          expected_d  = 8'h00;
          match_cnt_d = '0;
          miss_cnt_d  = '0;
        end
      endcase
    end
  end

  assign o_lock = lock_q;
  assign o_err  = err_q;

`ifdef LFSR_SYNC_RX_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating count of locked mismatches; a clear wins over a same-cycle increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    if (i_clr_cnt) err_cnt_d = 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) err_cnt_q <= 16'h0000;
    else          err_cnt_q <= err_cnt_d;
  end

  assign o_err_cnt = err_cnt_q;
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = i_clr_cnt;
  assign o_err_cnt      = 16'h0000;
`endif

endmodule

// File: tb/tb_lfsr_sync_rx.sv
// Self-checking bench for lfsr_sync_rx: a cycle model pushes the expected outputs
// for every driven cycle into a queue; each scenario task pops and compares after the edge.
// Error-count expectations follow the LFSR_SYNC_RX_ERR_CNT_EN setting of the build.
module tb_lfsr_sync_rx;

  localparam int LOCK_CNT   = 5;
  localparam int UNLOCK_CNT = 3;
`ifdef LFSR_SYNC_RX_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic [7:0]  i_lfsr;
  logic        i_clr_cnt;
  logic        o_lock;
  logic        o_err;
  logic [15:0] o_err_cnt;

  always #5 clk = ~clk;

  lfsr_sync_rx #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)) dut (
    .clk       (clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .i_lfsr    (i_lfsr),
    .i_clr_cnt (i_clr_cnt),
    .o_lock    (o_lock),
    .o_err     (o_err),
    .o_err_cnt (o_err_cnt)
  );

  typedef struct packed {
    logic        lock;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state (0 = search, 1 = verify, 2 = locked).
  int          m_state = 0;
  logic [7:0]  m_exp   = 8'h00;
  int          m_match = 0;
  int          m_miss  = 0;
  logic        m_lock  = 1'b0;
  logic        m_err   = 1'b0;
  logic [15:0] m_cnt   = 16'h0000;

  // Same sequence written as shift-left then conditional XOR with taps 0x1D.
  function automatic logic [7:0] nxt(input logic [7:0] x);
    logic f;
    f = x[7] ^ (x[6:0] == 7'd0);
    return {x[6:0], 1'b0} ^ (f ? 8'h1D : 8'h00);
  endfunction

  // Drive one cycle, advance the model, queue its expectation, sample after the edge.
  task automatic step(input logic v, input logic [7:0] w, input logic c, input logic r);
    exp_t e;
    logic hit;
    @(negedge clk);
    i_valid = v; i_lfsr = w; i_clr_cnt = c; i_rst_n = r;
    if (!r) begin
      m_state = 0; m_exp = 8'h00; m_match = 0; m_miss = 0;
      m_lock = 1'b0; m_err = 1'b0; m_cnt = 16'h0000;
    end else begin
      m_err = 1'b0;
      if (v) begin
        hit = (w == m_exp);
        case (m_state)
          0: begin m_exp = nxt(w); m_match = 0; m_state = 1; end
          1: begin
            m_exp = nxt(w);
            if (hit) begin
              m_match++;
              if (m_match == LOCK_CNT) begin m_state = 2; m_miss = 0; end
            end else m_match = 0;
          end
          default: begin
            m_exp = nxt(m_exp);
            if (hit) m_miss = 0;
            else begin
              m_err = 1'b1;
              if (CNT_EN && m_cnt != 16'hFFFF) m_cnt++;
              m_miss++;
              if (m_miss == UNLOCK_CNT) begin m_state = 0; m_miss = 0; m_match = 0; end
            end
          end
        endcase
      end
      if (c && CNT_EN) m_cnt = 16'h0000;
      m_lock = (m_state == 2);
    end
    e.lock = m_lock; e.err = m_err; e.cnt = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hA5, 1'b1, 1'b0);
      e = sb_q.pop_front();
      checks++; if (o_lock !== 1'b0) begin errors++; $display("FAIL reset_lock[%0d] got=%b exp=0", i, o_lock); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err[%0d] got=%b exp=0", i, o_err); end
      checks++; if (o_err_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cnt[%0d] got=%h exp=0000", i, o_err_cnt); end
      checks++; if ({o_lock, o_err, o_err_cnt} !== {e.lock, e.err, e.cnt}) begin
        errors++; $display("FAIL reset_sb[%0d] got=%b/%b/%h exp=%b/%b/%h", i, o_lock, o_err, o_err_cnt, e.lock, e.err, e.cnt);
      end
    end
  endtask

  // Six ascending words acquire lock on the sixth.
  task automatic test_lock();
    exp_t e;
    logic [7:0] w = 8'h01;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, w, 1'b0, 1'b1);
      e = sb_q.pop_front();
      checks++; if (o_lock !== e.lock) begin errors++; $display("FAIL lock_lock[%0d] got=%b exp=%b", i, o_lock, e.lock); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL lock_err[%0d] got=%b exp=0", i, o_err); end
      checks++; if (o_err_cnt !== e.cnt) begin errors++; $display("FAIL lock_cnt[%0d] got=%h exp=%h", i, o_err_cnt, e.cnt); end
      if (i == 4) begin checks++; if (o_lock !== 1'b0) begin errors++; $display("FAIL lock_early got=%b exp=0", o_lock); end end
      if (i == 5) begin checks++; if (o_lock !== 1'b1) begin errors++; $display("FAIL lock_sixth got=%b exp=1", o_lock); end end
      w = w << 1;
    end
  endtask

  // One bad word in place of 0x40, then the correct 0x80 and an idle cycle.
  task automatic test_single_err();
    exp_t e;
    logic [7:0] words [3] = '{8'h55, 8'h80, 8'h00};
    logic       vals  [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step(vals[i], words[i], 1'b0, 1'b1);
      e = sb_q.pop_front();
      checks++; if (o_lock !== 1'b1) begin errors++; $display("FAIL serr_lock[%0d] got=%b exp=1", i, o_lock); end
      checks++; if (o_err !== (i == 0)) begin errors++; $display("FAIL serr_err[%0d] got=%b exp=%b", i, o_err, (i == 0)); end
      checks++; if (o_err_cnt !== (CNT_EN ? 16'd1 : 16'd0)) begin errors++; $display("FAIL serr_cnt[%0d] got=%h exp=%h", i, o_err_cnt, (CNT_EN ? 16'd1 : 16'd0)); end
      checks++; if ({o_lock, o_err, o_err_cnt} !== {e.lock, e.err, e.cnt}) begin
        errors++; $display("FAIL serr_sb[%0d] got=%b/%b/%h exp=%b/%b/%h", i, o_lock, o_err, o_err_cnt, e.lock, e.err, e.cnt);
      end
    end
  endtask

  // Clear the count, three bad words drop lock, six good words relock.
  task automatic test_unlock();
    exp_t e;
    logic [7:0] w = 8'h01;
    step(1'b0, 8'h00, 1'b1, 1'b1);
    e = sb_q.pop_front();
    checks++; if (o_err_cnt !== 16'h0000) begin errors++; $display("FAIL unlock_clr got=%h exp=0000", o_err_cnt); end
    for (int i = 0; i < 9; i++) begin
      if (i < 3) step(1'b1, 8'hAA, 1'b0, 1'b1);
      else begin step(1'b1, w, 1'b0, 1'b1); w = w << 1; end
      e = sb_q.pop_front();
      checks++; if (o_lock !== e.lock) begin errors++; $display("FAIL unlock_lock[%0d] got=%b exp=%b", i, o_lock, e.lock); end
      checks++; if (o_err !== e.err) begin errors++; $display("FAIL unlock_err[%0d] got=%b exp=%b", i, o_err, e.err); end
      checks++; if (o_err_cnt !== e.cnt) begin errors++; $display("FAIL unlock_cnt[%0d] got=%h exp=%h", i, o_err_cnt, e.cnt); end
      if (i == 1) begin checks++; if (o_lock !== 1'b1) begin errors++; $display("FAIL unlock_hold got=%b exp=1", o_lock); end end
      if (i == 2) begin
        checks++; if (o_lock !== 1'b0) begin errors++; $display("FAIL unlock_drop got=%b exp=0", o_lock); end
        checks++; if (o_err_cnt !== (CNT_EN ? 16'd3 : 16'd0)) begin errors++; $display("FAIL unlock_cnt3 got=%h exp=%h", o_err_cnt, (CNT_EN ? 16'd3 : 16'd0)); end
      end
      if (i == 7) begin checks++; if (o_lock !== 1'b0) begin errors++; $display("FAIL relock_early got=%b exp=0", o_lock); end end
      if (i == 8) begin checks++; if (o_lock !== 1'b1) begin errors++; $display("FAIL relock got=%b exp=1", o_lock); end end
    end
  endtask

  // Idle gaps of two cycles between accepted words; 0x00 is a legal member.
  task automatic test_gaps();
    exp_t e;
    logic [7:0] words [6] = '{8'h40, 8'h80, 8'h00, 8'h1D, 8'h3A, 8'h74};
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    void'(sb_q.pop_front());
    for (int i = 0; i < 6; i++) begin
      for (int g = 0; g < 3; g++) begin
        step(g == 0, (g == 0) ? words[i] : 8'hFF, 1'b0, 1'b1);
        e = sb_q.pop_front();
        checks++; if (o_lock !== e.lock) begin errors++; $display("FAIL gaps_lock[%0d.%0d] got=%b exp=%b", i, g, o_lock, e.lock); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL gaps_err[%0d.%0d] got=%b exp=0", i, g, o_err); end
      end
      if (i == 4) begin checks++; if (o_lock !== 1'b0) begin errors++; $display("FAIL gaps_early got=%b exp=0", o_lock); end end
      if (i == 5) begin checks++; if (o_lock !== 1'b1) begin errors++; $display("FAIL gaps_lock6 got=%b exp=1", o_lock); end end
    end
  endtask

  // Two errors while locked, then reset with i_valid high discards everything.
  task automatic test_reset_mid();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0, 1:    step(1'b1, 8'hAA, 1'b0, 1'b1);
        2:       step(1'b1, 8'h01, 1'b1, 1'b0);
        default: step(1'b1, (i == 3) ? 8'h01 : 8'h02, 1'b0, 1'b1);
      endcase
      e = sb_q.pop_front();
      checks++; if (o_lock !== e.lock) begin errors++; $display("FAIL rmid_lock[%0d] got=%b exp=%b", i, o_lock, e.lock); end
      checks++; if (o_err !== e.err) begin errors++; $display("FAIL rmid_err[%0d] got=%b exp=%b", i, o_err, e.err); end
      checks++; if (o_err_cnt !== e.cnt) begin errors++; $display("FAIL rmid_cnt[%0d] got=%h exp=%h", i, o_err_cnt, e.cnt); end
      if (i == 1) begin checks++; if (o_err_cnt !== (CNT_EN ? 16'd2 : 16'd0)) begin errors++; $display("FAIL rmid_cnt2 got=%h exp=%h", o_err_cnt, (CNT_EN ? 16'd2 : 16'd0)); end end
      if (i == 2) begin
        checks++; if (o_lock !== 1'b0) begin errors++; $display("FAIL rmid_lock0 got=%b exp=0", o_lock); end
        checks++; if (o_err_cnt !== 16'h0000) begin errors++; $display("FAIL rmid_cnt0 got=%h exp=0000", o_err_cnt); end
      end
    end
  endtask

  // Reseed in VERIFY on a wrong word, then lock on five back-to-back matches.
  task automatic test_back_to_back();
    exp_t e;
    logic [7:0] w;
    step(1'b1, 8'h00, 1'b0, 1'b0);
    void'(sb_q.pop_front());
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: w = 8'h01;
        1: w = 8'h02;
        2: w = 8'h04;
        3: w = 8'h77;
        default: w = nxt(w);
      endcase
      step(1'b1, w, 1'b0, 1'b1);
      e = sb_q.pop_front();
      checks++; if (o_lock !== e.lock) begin errors++; $display("FAIL b2b_lock[%0d] got=%b exp=%b", i, o_lock, e.lock); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL b2b_err[%0d] got=%b exp=0", i, o_err); end
      if (i == 7) begin checks++; if (o_lock !== 1'b0) begin errors++; $display("FAIL b2b_early got=%b exp=0", o_lock); end end
      if (i == 8) begin checks++; if (o_lock !== 1'b1) begin errors++; $display("FAIL b2b_lock5 got=%b exp=1", o_lock); end end
    end
    test_clr_collision(w);
  endtask

  // Mismatch with a simultaneous clear: count ends at zero, pulse still fires.
  task automatic test_clr_collision(input logic [7:0] last);
    exp_t e;
    logic [7:0] x = last;
    for (int i = 0; i < 3; i++) begin
      x = nxt(x);
      step(1'b1, (i < 2) ? (x ^ 8'hFF) : x, (i == 1), 1'b1);
      e = sb_q.pop_front();
      checks++; if (o_lock !== 1'b1) begin errors++; $display("FAIL clr_lock[%0d] got=%b exp=1", i, o_lock); end
      checks++; if (o_err !== e.err) begin errors++; $display("FAIL clr_err[%0d] got=%b exp=%b", i, o_err, e.err); end
      checks++; if (o_err_cnt !== e.cnt) begin errors++; $display("FAIL clr_cnt[%0d] got=%h exp=%h", i, o_err_cnt, e.cnt); end
      if (i == 0) begin checks++; if (o_err_cnt !== (CNT_EN ? 16'd1 : 16'd0)) begin errors++; $display("FAIL clr_pre got=%h exp=%h", o_err_cnt, (CNT_EN ? 16'd1 : 16'd0)); end end
      if (i == 1) begin
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL clr_pulse got=%b exp=1", o_err); end
        checks++; if (o_err_cnt !== 16'h0000) begin errors++; $display("FAIL clr_win got=%h exp=0000", o_err_cnt); end
      end
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b1; i_clr_cnt = 1'b1; i_lfsr = 8'hA5;
    test_reset();
    test_lock();
    test_single_err();
    test_unlock();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

endmodule
